pipe_stage_buf: RTL and testbench

Parametrised, multi-entry pipeline stage buffer with a valid/ready handshake, hold-code stall and flush. It replaces the fixed single-register stage latches between decode and execute, and is reusable at any stage boundary. Decoded bundles are packed into one `WIDTH`-bit payload by the producing stage.

---
 rtl/pipe_stage_buf_pkg.sv | 34 +++
 rtl/pipe_buf_ctrl.sv | 86 ++++++++
 rtl/pipe_stage_buf.sv | 85 ++++++++
 tb/tb_pipe_stage_buf.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared hold-code definitions and helpers for the stage buffer
//
// Purpose : provides the global hold-code bus width and hold levels, plus the
//           hold comparison used at every stage boundary.
// Macros  : BUS_HOLD_CODE, HOLD_CODE_NONE, HOLD_CODE_IF, HOLD_CODE_ID,
//           HOLD_CODE_EX, HOLD_CODE_ALL, HOLD_EN, HOLD_DIS
`ifndef PIPE_STAGE_BUF_DEFINES
`define PIPE_STAGE_BUF_DEFINES
`define BUS_HOLD_CODE  2:0
`define HOLD_CODE_NONE 3'd0
`define HOLD_CODE_IF   3'd1
`define HOLD_CODE_ID   3'd2
`define HOLD_CODE_EX   3'd3
`define HOLD_CODE_ALL  3'd7
`define HOLD_EN        1'b1
`define HOLD_DIS       1'b0
`endif

package pipe_stage_buf_pkg;

   localparam logic [`BUS_HOLD_CODE] HOLD_NONE = `HOLD_CODE_NONE;
   localparam logic [`BUS_HOLD_CODE] HOLD_IF   = `HOLD_CODE_IF;
   localparam logic [`BUS_HOLD_CODE] HOLD_ID   = `HOLD_CODE_ID;
   localparam logic [`BUS_HOLD_CODE] HOLD_EX   = `HOLD_CODE_EX;
   localparam logic [`BUS_HOLD_CODE] HOLD_ALL  = `HOLD_CODE_ALL;

   // A stage is stalled by any hold code at or above its own level, so deeper
   // stalls (higher codes) freeze every earlier boundary as well.
   function automatic logic is_held(input logic [`BUS_HOLD_CODE] code,
                                    input logic [`BUS_HOLD_CODE] level);
      return (code >= level) ? `HOLD_EN : `HOLD_DIS;
   endfunction

endpackage

// File: rtl/pipe_buf_ctrl.sv
// rtl/pipe_buf_ctrl.sv - pointer, occupancy and priority control for the stage buffer
//
// Purpose : owns the read/write pointers and occupancy counter and resolves
//           reset > flush > hold > push/pop.
// Ports   : clk, rst          clock, async active-high reset
//           hold_i, flush_i   stall and discard requests
//           in_valid_i        producer has a payload
//           out_ready_i       consumer takes the head
//           bypass_take_i     payload consumed by the bypass path, do not store
//           in_ready_o        space available and not held
//           buf_valid_o       stored head entry is presentable
//           wr_en_o, wr_idx_o entry array write strobe and index
//           rd_idx_o          head entry index
//           count_o           occupancy 0..DEPTH
module pipe_buf_ctrl
   import pipe_stage_buf_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hold_i,
   input  logic          flush_i,
   input  logic          in_valid_i,
   input  logic          out_ready_i,
   input  logic          bypass_take_i,
   output logic          in_ready_o,
   output logic          buf_valid_o,
   output logic          wr_en_o,
   output logic [PW-1:0] wr_idx_o,
   output logic [PW-1:0] rd_idx_o,
   output logic [CW-1:0] count_o
);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push;
   logic          pop;

   // Readiness ignores out_ready_i so no consumer-to-producer comb path exists.
   assign in_ready_o  = ~rst & ~hold_i & (count_q < CW'(DEPTH));
   assign buf_valid_o = ~hold_i & (count_q != '0);
   assign push        = in_valid_i & in_ready_o & ~bypass_take_i;
   assign pop         = buf_valid_o & out_ready_i;
   // A push in a flush cycle is dropped, so it must not touch the array either.
   assign wr_en_o     = push & ~flush_i;
   assign wr_idx_o    = wr_ptr_q;
   assign rd_idx_o    = rd_ptr_q;
   assign count_o     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else if (!hold_i) begin
         // DEPTH is a power of two, so plain increment wraps DEPTH-1 to 0.
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - multi-entry pipeline stage buffer with hold and flush
//
// Purpose : valid/ready stage buffer between pipeline stages; entry array
//           plus optional zero-latency bypass (macro PIPE_BUF_BYPASS_EN).
// Ports   : clk, rst                         clock, async active-high reset
//           hold_code                        global stall code
//           flush_i                          discard all buffered entries
//           in_valid_i, in_ready_o, in_data_i    producer side
//           out_valid_o, out_ready_i, out_data_o consumer side
//           count_o                          occupancy 0..DEPTH
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter  int                       WIDTH      = 64,
   parameter  int                       DEPTH      = 2,
   parameter  logic [`BUS_HOLD_CODE]    HOLD_LEVEL = `HOLD_CODE_ID,
   localparam int                       PW         = $clog2(DEPTH),
   localparam int                       CW         = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [`BUS_HOLD_CODE] hold_code,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [WIDTH-1:0]      in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [WIDTH-1:0]      out_data_o,
   output logic [CW-1:0]         count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             hold;
   logic             buf_valid;
   logic             bypass_take;
   logic             wr_en;
   logic [PW-1:0]    wr_idx;
   logic [PW-1:0]    rd_idx;

   assign hold = is_held(hold_code, HOLD_LEVEL);

   pipe_buf_ctrl #(
      .DEPTH (DEPTH)
   ) u_ctrl (
      .clk           (clk),
      .rst           (rst),
      .hold_i        (hold),
      .flush_i       (flush_i),
      .in_valid_i    (in_valid_i),
      .out_ready_i   (out_ready_i),
      .bypass_take_i (bypass_take),
      .in_ready_o    (in_ready_o),
      .buf_valid_o   (buf_valid),
      .wr_en_o       (wr_en),
      .wr_idx_o      (wr_idx),
      .rd_idx_o      (rd_idx),
      .count_o       (count_o)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_idx] <= in_data_i;
      end
   end

`ifdef PIPE_BUF_BYPASS_EN
   logic bypass_act;

   // Empty buffer: present the incoming payload directly; if the consumer
   // takes it this cycle it never lands in the array.
   assign bypass_act  = ~rst & ~hold & ~flush_i & in_valid_i & (count_o == '0);
   assign bypass_take = bypass_act & out_ready_i;
   assign out_valid_o = buf_valid | bypass_act;
   assign out_data_o  = bypass_act ? in_data_i : mem_q[rd_idx];
`else
   assign bypass_take = 1'b0;
   assign out_valid_o = buf_valid;
   // Stale entry shows while empty; out_valid_o qualifies it.
   assign out_data_o  = mem_q[rd_idx];
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf
module tb_pipe_stage_buf;
   import pipe_stage_buf_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  hold_code;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;

   logic        ir2, ov2, ir4, ov4;
   logic [63:0] od2, od4;
   logic [1:0]  cnt2;
   logic [2:0]  cnt4;

   int n_chk = 0;
   int n_err = 0;
   logic [63:0] got_q[$];

   always #5 clk = ~clk;

   pipe_stage_buf #(.WIDTH(64), .DEPTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .hold_code(hold_code), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(ir2), .in_data_i(in_data),
      .out_valid_o(ov2), .out_ready_i(out_ready), .out_data_o(od2), .count_o(cnt2)
   );

   pipe_stage_buf #(.WIDTH(64), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .hold_code(hold_code), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(ir4), .in_data_i(in_data),
      .out_valid_o(ov4), .out_ready_i(out_ready), .out_data_o(od4), .count_o(cnt4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; hold_code = HOLD_NONE; flush = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; hold_code = HOLD_NONE; flush = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #2;
      check("rst_in_ready", ir2, 0);
      check("rst_out_valid", ov2, 0);
      check("rst_out_data", od2, 0);
      check("rst_count", cnt2, 0);
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rel_in_ready", ir2, 1);

      // DEPTH=2 fill, reject third push, drain in order
      drive(1, 64'h11, 0);
      tick();
      check("lat_valid", ov2, 1);
      check("lat_data", od2, 64'h11);
      check("fill1_count", cnt2, 1);
      drive(1, 64'h22, 0);
      tick();
      check("full_count", cnt2, 2);
      check("full_in_ready", ir2, 0);
      drive(1, 64'h33, 0);
      tick();
      check("full_hold_count", cnt2, 2);
      drive(0, 64'h0, 1);
      check("pop1_data", od2, 64'h11);
      tick();
      check("pop2_data", od2, 64'h22);
      check("pop2_count", cnt2, 1);
      tick();
      check("drained_count", cnt2, 0);
      check("drained_valid", ov2, 0);

      // DEPTH=4 streaming through two pointer wraps
      do_reset();
      got_q.delete();
      for (int k = 1; k <= 9; k++) begin
         drive(1, 64'(k), 1);
         if (ov4) got_q.push_back(od4);
         tick();
      end
      drive(0, 64'h0, 1);
`ifdef PIPE_BUF_BYPASS_EN
      check("stream_settle_count", cnt4, 0);
`else
      check("stream_settle_count", cnt4, 1);
`endif
      for (int c = 0; c < 6; c++) begin
         if (ov4) got_q.push_back(od4);
         tick();
      end
      check("stream_len", 64'(got_q.size()), 9);
      for (int i = 0; i < got_q.size() && i < 9; i++)
         check($sformatf("stream_order%0d", i), got_q[i], 64'(i + 1));

      // Hold with three entries buffered
      do_reset();
      drive(1, 64'hA1, 0); tick();
      drive(1, 64'hA2, 0); tick();
      drive(1, 64'hA3, 0); tick();
      check("hold_pre_count", cnt4, 3);
      hold_code = HOLD_IF;
      drive(0, 64'h0, 0);
      check("below_level_ready", ir4, 1);
      hold_code = HOLD_ID;
      for (int c = 0; c < 4; c++) begin
         drive(1, 64'hEE, 1);
         check($sformatf("hold_ready%0d", c), ir4, 0);
         check($sformatf("hold_valid%0d", c), ov4, 0);
         check($sformatf("hold_count%0d", c), cnt4, 3);
         tick();
      end
      hold_code = HOLD_NONE;
      drive(0, 64'h0, 0);
      check("unhold_valid", ov4, 1);
      check("unhold_head", od4, 64'hA1);
      check("unhold_ready", ir4, 1);

      // Flush with a same-cycle push
      do_reset();
      drive(1, 64'hB1, 0); tick();
      drive(1, 64'hB2, 0); tick();
      flush = 1'b1;
      drive(1, 64'hAA, 0);
      check("flush_in_ready", ir4, 1);
      tick();
      flush = 1'b0;
      drive(0, 64'h0, 0);
      check("flush_count", cnt4, 0);
      check("flush_valid", ov4, 0);
      drive(1, 64'h77, 0);
      tick();
      drive(0, 64'h0, 0);
      check("post_flush_count", cnt4, 1);
      check("post_flush_head", od4, 64'h77);

      // Flush while held
      do_reset();
      drive(1, 64'hC1, 0); tick();
      drive(1, 64'hC2, 0); tick();
      hold_code = HOLD_ALL;
      flush = 1'b1;
      drive(0, 64'h0, 0);
      check("flushhold_ready", ir4, 0);
      tick();
      flush = 1'b0;
      #1;
      check("flushhold_count", cnt4, 0);
      hold_code = HOLD_NONE;
      #1;
      check("flushhold_valid", ov4, 0);

      // Bypass behaviour on an empty buffer
      do_reset();
      drive(1, 64'h5A, 1);
`ifdef PIPE_BUF_BYPASS_EN
      check("bypass_valid", ov4, 1);
      check("bypass_data", od4, 64'h5A);
`else
      check("bypass_valid", ov4, 0);
`endif
      tick();
      drive(0, 64'h0, 0);
`ifdef PIPE_BUF_BYPASS_EN
      check("bypass_count", cnt4, 0);
      check("bypass_after_valid", ov4, 0);
`else
      check("bypass_count", cnt4, 1);
      check("bypass_after_data", od4, 64'h5A);
`endif

      // Asynchronous reset mid-stream
      drive(1, 64'hD1, 0); tick();
      drive(0, 64'h0, 0);
      rst = 1'b1;
      #1;
      check("async_rst_ready", ir4, 0);
      check("async_rst_valid", ov4, 0);
      check("async_rst_count", cnt4, 0);
      check("async_rst_data", od4, 0);
      tick();
      rst = 1'b0;
      #1;
      check("async_rel_ready", ir4, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
